// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined shift/rotate node (SHL/SHR/SRA/ROL/ROR).
// A log2(N)-level barrel shifter is split across STAGES register stages.
// Each token carries its op, sign, oversize flag and partial overflow with it.
module shift_unit_pipe #(
    parameter int N      = 16,
    parameter int STAGES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         R_IN1,
    input  logic [N-1:0] D_IN1,
    input  logic         R_IN2,
    input  logic [N-1:0] D_IN2,
    input  logic [2:0]   OP,
    output logic         R_OUT,
    output logic [N-1:0] D_OUT,
    output logic         OVF
);

    localparam int LOG2N = $clog2(N);
    // Barrel levels per stage; the first REM stages take one extra level.
    localparam int BASE  = LOG2N / STAGES;
    localparam int REM   = LOG2N % STAGES;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef struct packed {
        logic [N-1:0]     data;
        logic [LOG2N-1:0] amt;
        logic [2:0]       op;
        logic             sign;
        logic             big;
        logic             ovf;
    } tok_t;

    // One barrel level: shift/rotate by 2^k when amount bit k is set.
    // For SHL the bits pushed off the top are folded into the overflow flag,
    // so the total over all levels is "any 1 bit shifted out".
    function automatic tok_t apply_level(input tok_t t, input int k);
        tok_t r;
        int   sh;
        r  = t;
        sh = 1 << k;
        if (t.amt[k]) begin
            case (t.op)
                OP_SHL: begin
                    r.ovf  = t.ovf | (|(t.data >> (N - sh)));
                    r.data = t.data << sh;
                end
                OP_SHR: r.data = t.data >> sh;
                OP_SRA: r.data = (t.data >> sh) | (t.sign ? ~({N{1'b1}} >> sh) : '0);
                OP_ROL: r.data = (t.data << sh) | (t.data >> (N - sh));
                OP_ROR: r.data = (t.data >> sh) | (t.data << (N - sh));
                default: ;
            endcase
        end
        return r;
    endfunction

    // Final fix-up after all levels: oversize amounts and reserved ops.
    // For SHL with BIG, the operand was non-zero iff bits remain or some
    // were already shifted out, so the partial flag plus |data suffices.
    function automatic logic [N:0] finish(input tok_t t);
        logic [N-1:0] d;
        logic         o;
        d = t.data;
        o = t.ovf;
        case (t.op)
            OP_SHL: if (t.big) begin
                o = t.ovf | (|t.data);
                d = '0;
            end
            OP_SHR: if (t.big) d = '0;
            OP_SRA: if (t.big) d = {N{t.sign}};
            OP_ROL, OP_ROR: ;
            default: begin
                d = '0;
                o = 1'b1;
            end
        endcase
        return {o, d};
    endfunction

    tok_t tok_in   [STAGES];
    logic vld_pipe [STAGES+1];

    assign vld_pipe[0] = R_IN1 & R_IN2;
    assign tok_in[0]   = '{data: D_IN1,
                           amt:  D_IN2[LOG2N-1:0],
                           op:   OP,
                           sign: D_IN1[N-1],
                           big:  |D_IN2[N-1:LOG2N],
                           ovf:  1'b0};

    genvar s;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            localparam int LO  = s * BASE + ((s < REM) ? s : REM);
            localparam int CNT = BASE + ((s < REM) ? 1 : 0);

            tok_t t_nx;
            logic vld_q;

            // Combinational barrel levels owned by this stage.
            always_comb begin
                t_nx = tok_in[s];
                for (int k = LO; k < LO + CNT; k++) begin
                    t_nx = apply_level(t_nx, k);
                end
            end

            // Valid bit advances on every enabled edge; bubbles pass through.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST)    vld_q <= 1'b0;
                else if (EN) vld_q <= vld_pipe[s];
            end
            assign vld_pipe[s+1] = vld_q;

            if (s < STAGES - 1) begin : g_mid
                tok_t q;
                // Token data only moves with a valid token; bubbles leave it.
                always_ff @(posedge CLK or negedge RST) begin
                    if (!RST)                  q <= '0;
                    else if (EN && vld_pipe[s]) q <= t_nx;
                end
                assign tok_in[s+1] = q;
            end else begin : g_last
                logic [N:0]   fin;
                logic [N-1:0] d_q;
                logic         ovf_q;
                assign fin = finish(t_nx);
                // Output registers keep the last valid result across bubbles.
                always_ff @(posedge CLK or negedge RST) begin
                    if (!RST) begin
                        d_q   <= '0;
                        ovf_q <= 1'b0;
                    end else if (EN && vld_pipe[s]) begin
                        d_q   <= fin[N-1:0];
                        ovf_q <= fin[N];
                    end
                end
                assign D_OUT = d_q;
                assign OVF   = ovf_q;
            end
        end
    endgenerate

    assign R_OUT = vld_pipe[STAGES];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: three instances (STAGES=1,2,4, N=16)
// share one stimulus stream; each output is checked at its own latency.
module tb_shift_unit_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        R_IN1, R_IN2;
    logic [15:0] D_IN1, D_IN2;
    logic [2:0]  OP;

    logic        r1, r2, r4;
    logic [15:0] d1, d2, d4;
    logic        o1, o2, o4;

    int checks = 0;
    int errors = 0;

    shift_unit_pipe #(.N(16), .STAGES(1)) u_s1 (
        .CLK(CLK), .RST(RST), .EN(EN), .R_IN1(R_IN1), .D_IN1(D_IN1),
        .R_IN2(R_IN2), .D_IN2(D_IN2), .OP(OP), .R_OUT(r1), .D_OUT(d1), .OVF(o1));
    shift_unit_pipe #(.N(16), .STAGES(2)) u_s2 (
        .CLK(CLK), .RST(RST), .EN(EN), .R_IN1(R_IN1), .D_IN1(D_IN1),
        .R_IN2(R_IN2), .D_IN2(D_IN2), .OP(OP), .R_OUT(r2), .D_OUT(d2), .OVF(o2));
    shift_unit_pipe #(.N(16), .STAGES(4)) u_s4 (
        .CLK(CLK), .RST(RST), .EN(EN), .R_IN1(R_IN1), .D_IN1(D_IN1),
        .R_IN2(R_IN2), .D_IN2(D_IN2), .OP(OP), .R_OUT(r4), .D_OUT(d4), .OVF(o4));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic v1, input logic v2, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] op);
        R_IN1 = v1;
        R_IN2 = v2;
        D_IN1 = a;
        D_IN2 = b;
        OP    = op;
    endtask

    // One isolated token; checks each instance exactly at its latency.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [15:0] ed, input logic eo);
        put(1'b1, 1'b1, a, b, op);
        tick();
        put(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        chk({tag, " s1 r"}, 32'(r1), 32'(1'b1));
        chk({tag, " s1 d"}, 32'(d1), 32'(ed));
        chk({tag, " s1 ovf"}, 32'(o1), 32'(eo));
        chk({tag, " s2 r early"}, 32'(r2), 32'(1'b0));
        tick();
        chk({tag, " s1 r bubble"}, 32'(r1), 32'(1'b0));
        chk({tag, " s1 d held"}, 32'(d1), 32'(ed));
        chk({tag, " s2 r"}, 32'(r2), 32'(1'b1));
        chk({tag, " s2 d"}, 32'(d2), 32'(ed));
        chk({tag, " s2 ovf"}, 32'(o2), 32'(eo));
        tick();
        chk({tag, " s4 r early"}, 32'(r4), 32'(1'b0));
        tick();
        chk({tag, " s4 r"}, 32'(r4), 32'(1'b1));
        chk({tag, " s4 d"}, 32'(d4), 32'(ed));
        chk({tag, " s4 ovf"}, 32'(o4), 32'(eo));
        tick();
    endtask

    initial begin
        int  cnt1, cnt2, cnt4, sent;
        bit  en_c;
        logic [15:0] exp_d;
        logic        exp_r;

        EN = 1'b1;
        put(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        chk("reset r1", 32'(r1), 32'd0);
        chk("reset d1", 32'(d1), 32'd0);
        chk("reset r2", 32'(r2), 32'd0);
        chk("reset d2", 32'(d2), 32'd0);
        chk("reset ovf2", 32'(o2), 32'd0);
        chk("reset r4", 32'(r4), 32'd0);
        chk("reset d4", 32'(d4), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        tick();

        // Function vectors (op: 0 SHL, 1 SHR, 2 SRA, 3 ROL, 4 ROR)
        run_op("shl f0<<4",   16'h00F0, 16'd4,     3'd0, 16'h0F00, 1'b0);
        run_op("shl 8001<<1", 16'h8001, 16'd1,     3'd0, 16'h0002, 1'b1);
        run_op("shr by20",    16'h8000, 16'd20,    3'd1, 16'h0000, 1'b0);
        run_op("sra by20",    16'h8000, 16'd20,    3'd2, 16'hFFFF, 1'b0);
        run_op("rol by17",    16'h8001, 16'd17,    3'd3, 16'h0003, 1'b0);
        run_op("ror by4",     16'h0001, 16'd4,     3'd4, 16'h1000, 1'b0);
        run_op("op6",         16'h1234, 16'd3,     3'd6, 16'h0000, 1'b1);
        run_op("sra by3",     16'h8000, 16'd3,     3'd2, 16'hF000, 1'b0);
        run_op("sra pos",     16'h7000, 16'd4,     3'd2, 16'h0700, 1'b0);
        run_op("shl 1<<15",   16'h0001, 16'd15,    3'd0, 16'h8000, 1'b0);
        run_op("shl 3<<15",   16'h0003, 16'd15,    3'd0, 16'h8000, 1'b1);
        run_op("shl big nz",  16'h0001, 16'd16,    3'd0, 16'h0000, 1'b1);
        run_op("shl big z",   16'h0000, 16'h0100,  3'd0, 16'h0000, 1'b0);
        run_op("shl amt0",    16'hFFFF, 16'd0,     3'd0, 16'hFFFF, 1'b0);
        run_op("ror by31",    16'h8001, 16'd31,    3'd4, 16'h0003, 1'b0);

        // Stream of 8 tokens (value k+1, SHL by 1) with EN low for 3 cycles
        cnt1 = 0; cnt2 = 0; cnt4 = 0; sent = 0;
        for (int c = 0; c < 16; c++) begin
            en_c = !(c >= 4 && c <= 6);
            EN   = en_c;
            if (sent < 8) put(1'b1, 1'b1, 16'(sent + 1), 16'd1, 3'd0);
            else          put(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
            tick();
            if (en_c && sent < 8) sent++;
            if (en_c) begin
                if (r1) begin chk("stream s1 d", 32'(d1), 32'(2 * (cnt1 + 1))); cnt1++; end
                if (r2) begin chk("stream s2 d", 32'(d2), 32'(2 * (cnt2 + 1))); cnt2++; end
                if (r4) begin chk("stream s4 d", 32'(d4), 32'(2 * (cnt4 + 1))); cnt4++; end
            end else begin
                chk("freeze s1 r", 32'(r1), 32'd1);
                chk("freeze s1 d", 32'(d1), 32'(2 * cnt1));
                chk("freeze s2 r", 32'(r2), 32'd1);
                chk("freeze s2 d", 32'(d2), 32'(2 * cnt2));
                chk("freeze s4 r", 32'(r4), 32'd1);
                chk("freeze s4 d", 32'(d4), 32'(2 * cnt4));
            end
        end
        EN = 1'b1;
        chk("stream s1 count", 32'(cnt1), 32'd8);
        chk("stream s2 count", 32'(cnt2), 32'd8);
        chk("stream s4 count", 32'(cnt4), 32'd8);

        // R_IN2 low on the third cycle of a 5-cycle stream
        for (int e = 0; e <= 5; e++) begin
            if (e == 2)     put(1'b1, 1'b0, 16'hDEAD, 16'd0, 3'd0);
            else if (e < 5) put(1'b1, 1'b1, 16'(16'h10 + e), 16'd0, 3'd0);
            else            put(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
            tick();
            if (e >= 1) begin
                exp_r = ((e - 1) != 2);
                exp_d = exp_r ? 16'(16'h10 + e - 1) : 16'h0011;
                chk("bubble s2 r", 32'(r2), 32'(exp_r));
                chk("bubble s2 d", 32'(d2), 32'(exp_d));
            end
        end
        for (int i = 0; i < 4; i++) tick();

        // Asynchronous reset with two tokens in flight
        put(1'b1, 1'b1, 16'h00F0, 16'd4, 3'd0);
        tick();
        put(1'b1, 1'b1, 16'h0001, 16'd4, 3'd4);
        tick();
        put(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        chk("pre-rst s2 r", 32'(r2), 32'd1);
        chk("pre-rst s1 d", 32'(d1), 32'h1000);
        #1 RST = 1'b0;
        #1;
        chk("async rst r1", 32'(r1), 32'd0);
        chk("async rst d1", 32'(d1), 32'd0);
        chk("async rst r2", 32'(r2), 32'd0);
        chk("async rst d2", 32'(d2), 32'd0);
        chk("async rst ovf2", 32'(o2), 32'd0);
        chk("async rst r4", 32'(r4), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post-rst s1 idle", 32'(r1), 32'd0);
            chk("post-rst s2 idle", 32'(r2), 32'd0);
            chk("post-rst s4 idle", 32'(r4), 32'd0);
        end
        run_op("post-rst sra", 16'h8001, 16'd1, 3'd2, 16'hC000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
